ddr3_port_arbiter: RTL

- Shares one DDR3 memory-controller user port (command FIFO, write-data FIFO, read-data FIFO) between two requesters, e.g. two ddr3_controller instances or a controller plus a DMA engine.
- Grants are round-robin and exclusive: the owner drives command and write paths until it releases.
- Read bursts are tagged at command issue, so returned read data is routed to the requester that issued each read, even after that requester has released the port.

---
 rtl/ddr3_pkg.sv | 27 ++
 rtl/ddr3_tag_fifo.sv | 50 +++++
 rtl/ddr3_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ddr3_pkg.sv
// Shared encodings and tag layout for the DDR3 user-port arbiter.
package ddr3_pkg;

    localparam logic [2:0] CMD_WRITE    = 3'b000;
    localparam logic [2:0] CMD_READ     = 3'b001;
    localparam logic [2:0] CMD_WRITE_PC = 3'b010;
    localparam logic [2:0] CMD_READ_PC  = 3'b011;
    localparam logic [2:0] CMD_REFRESH  = 3'b100;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int TAG_W = 1 + 6;

    typedef struct packed {
        logic       owner;
        logic [5:0] bl;
    } rd_tag_t;

    // Every read flavour has instr[0] set; writes and refresh do not.
    function automatic logic is_read(input logic [2:0] instr);
        return instr[0];
    endfunction

endpackage

// File: rtl/ddr3_tag_fifo.sv
// Read-tag FIFO: records {owner, burst length} per issued read, head is combinational.
module ddr3_tag_fifo
    import ddr3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  rd_tag_t       push_dat_i,
    input  logic          pop_i,
    output rd_tag_t       head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    rd_tag_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Round-robin exclusive owner of one DDR3 user port; reads are tagged at issue so
// returned data reaches its issuer regardless of who currently holds the port.
module ddr3_port_arbiter
    import ddr3_pkg::*;
#(
    parameter int TAG_DEPTH = 4,
    parameter int TAG_AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rq_req,
    output logic [1:0]        rq_gnt,
    input  logic [1:0]        rq_cmd_en,
    input  logic [5:0]        rq_cmd_instr,
    input  logic [11:0]       rq_cmd_bl,
    input  logic [55:0]       rq_cmd_addr,
    output logic [1:0]        rq_cmd_full,
    input  logic [1:0]        rq_wr_en,
    input  logic [7:0]        rq_wr_mask,
    input  logic [63:0]       rq_wr_data,
    output logic [1:0]        rq_wr_full,
    input  logic [1:0]        rq_rd_en,
    output logic [1:0]        rq_rd_empty,
    output logic [31:0]       rq_rd_data,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [27:0]       cmd_word_addr,
    input  logic              cmd_full,
    output logic              wr_en,
    output logic [3:0]        wr_mask,
    output logic [31:0]       wr_data,
    input  logic              wr_full,
    output logic              rd_en,
    input  logic [31:0]       rd_data,
    input  logic              rd_empty,
    output logic [TAG_AW:0]   reads_pending
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [5:0]  beat_q, beat_d;

    logic        granted, blk, tag_push, tag_pop, tag_empty;
    rd_tag_t     tag_head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            beat_q       <= beat_d;
        end
    end

    // Hand-over only happens from IDLE, which forces a gap cycle between owners.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (|rq_req) begin
                    owner_d = (&rq_req) ? ~last_owner_q : rq_req[1];
                    state_d = ARB_GRANT;
                    gnt_d   = owner_d ? 2'b10 : 2'b01;
                end
            end
            ARB_GRANT: begin
                if (!rq_req[owner_q]) begin
                    state_d      = ARB_IDLE;
                    gnt_d        = 2'b00;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign granted = (state_q == ARB_GRANT);

    always_comb begin
        cmd_instr     = owner_q ? rq_cmd_instr[5:3]  : rq_cmd_instr[2:0];
        cmd_bl        = owner_q ? rq_cmd_bl[11:6]    : rq_cmd_bl[5:0];
        cmd_word_addr = owner_q ? rq_cmd_addr[55:28] : rq_cmd_addr[27:0];
        wr_mask       = owner_q ? rq_wr_mask[7:4]    : rq_wr_mask[3:0];
        wr_data       = owner_q ? rq_wr_data[63:32]  : rq_wr_data[31:0];
        cmd_en        = granted & rq_cmd_en[owner_q] & ~cmd_full & ~blk;
        wr_en         = granted & rq_wr_en[owner_q] & ~wr_full;
        rq_cmd_full   = 2'b11;
        rq_wr_full    = 2'b11;
        if (granted) begin
            rq_cmd_full[owner_q] = cmd_full | blk;
            rq_wr_full[owner_q]  = wr_full;
        end
    end

    assign tag_push = cmd_en & is_read(cmd_instr);

    // Read return follows the head tag only; grant state plays no part here.
    always_comb begin
        rq_rd_empty                 = 2'b11;
        rq_rd_empty[tag_head.owner] = rd_empty | tag_empty;
        rd_en   = rq_rd_en[tag_head.owner] & ~rd_empty & ~tag_empty;
        tag_pop = rd_en & (beat_q == tag_head.bl);
        beat_d  = beat_q;
        if (rd_en) beat_d = tag_pop ? 6'd0 : beat_q + 6'd1;
    end

    ddr3_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .AW    (TAG_AW)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (tag_push),
        .push_dat_i ('{owner: owner_q, bl: cmd_bl}),
        .pop_i      (tag_pop),
        .head_o     (tag_head),
        .full_o     (blk),
        .empty_o    (tag_empty),
        .count_o    (reads_pending)
    );

    assign rq_gnt     = gnt_q;
    assign rq_rd_data = rd_data;

endmodule
